// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin priority arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic int unsigned idx_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational highest-index pick: prefers requesters at or below ptr,
// falling back to the highest requester overall when none qualify.
module rr_prio_pick #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         req,
  input  logic [$clog2(WIDTH)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(WIDTH)-1:0] win_idx,
  output logic [WIDTH-1:0]         win_onehot
);

  localparam int unsigned PW = $clog2(WIDTH);

  logic [WIDTH-1:0] masked;

  always_comb begin
    masked     = '0;
    found      = |req;
    win_idx    = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      masked[i] = req[i] && (PW'(i) <= ptr);
    end
    // Ascending scan: the last hit is the highest set index.
    if (|masked) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (masked[i]) win_idx = PW'(i);
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (req[i]) win_idx = PW'(i);
      end
    end
    if (found) win_onehot = WIDTH'(1) << win_idx;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with bounded grant tenure and registered outputs;
// grant_idx is index+1 with 0 meaning no grant.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                          CLK100MHZ,
  input  logic                          CPU_RESETN,
  input  logic [WIDTH-1:0]              req,
  output logic [WIDTH-1:0]              grant,
  output logic [idx_width(WIDTH)-1:0]   grant_idx,
  output logic                          busy
);

  localparam int unsigned PW = $clog2(WIDTH);
  localparam int unsigned IW = idx_width(WIDTH);
  // Unlimited hold never counts, so one bit is enough to keep the register legal.
  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    g;
  logic [HW-1:0]    hold_cnt;
  logic             found;
  logic [PW-1:0]    win_idx;
  logic [WIDTH-1:0] win_onehot;
  logic             rel;

  rr_prio_pick #(.WIDTH(WIDTH)) u_pick (
    .req        (req),
    .ptr        (ptr),
    .found      (found),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  always_comb begin
    rel = !req[g] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST));
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= ARB_IDLE;
      ptr       <= PW'(WIDTH - 1);
      g         <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            g         <= win_idx;
            grant     <= win_onehot;
            grant_idx <= IW'(win_idx) + IW'(1);
            busy      <= 1'b1;
            hold_cnt  <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (rel) begin
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            ptr       <= (g == '0) ? PW'(WIDTH - 1) : g - PW'(1);
            state     <= ARB_IDLE;
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge CLK100MHZ) disable iff (!CPU_RESETN)
    $onehot0(grant));
  a_busy: assert property (@(posedge CLK100MHZ) disable iff (!CPU_RESETN)
    busy == (|grant));
  a_idx: assert property (@(posedge CLK100MHZ) disable iff (!CPU_RESETN)
    (grant_idx == '0) == (grant == '0));
  a_req: assert property (@(posedge CLK100MHZ) disable iff (!CPU_RESETN)
    (busy && !$past(busy)) |-> (|(grant & $past(req))));

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Randomised and directed bench for rr_priority_arbiter against a rotating-search model.
module tb_rr_priority_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic [3:0] req2;
  logic [3:0] grant2;
  logic [2:0] grant_idx2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy;
  int m_ptr, m_g, m_cnt;

  rr_priority_arbiter #(.WIDTH(4), .MAX_HOLD(MH)) u_dut (
    .CLK100MHZ (clk), .CPU_RESETN (rst_n), .req (req),
    .grant (grant), .grant_idx (grant_idx), .busy (busy)
  );

  rr_priority_arbiter #(.WIDTH(4), .MAX_HOLD(0)) u_unl (
    .CLK100MHZ (clk), .CPU_RESETN (rst_n), .req (req2),
    .grant (grant2), .grant_idx (grant_idx2), .busy (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy = 0; m_ptr = 3; m_g = 0; m_cnt = 0;
  endfunction

  // Search downward from ptr, then downward from the top if nothing qualifies.
  function automatic void model_step(input logic [3:0] r);
    int w;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        w = -1;
        for (int i = m_ptr; i >= 0; i--) if (r[i] && w < 0) w = i;
        for (int i = 3; i >= 0; i--) if (r[i] && w < 0) w = i;
        m_busy = 1; m_g = w; m_cnt = 0;
      end
    end else if (!r[m_g] || (MH != 0 && m_cnt == MH - 1)) begin
      m_busy = 0;
      m_ptr  = (m_g == 0) ? 3 : m_g - 1;
    end else begin
      m_cnt++;
    end
  endfunction

  function automatic logic [3:0] exp_grant();
    return m_busy ? (4'b0001 << m_g) : 4'b0000;
  endfunction

  function automatic logic [2:0] exp_idx();
    return m_busy ? 3'(m_g + 1) : 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(req);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    req = 4'b1111;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: grant=%b idx=%0d busy=%b want 0000/0/0", grant, grant_idx, busy);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: grant=%b busy=%b want 0000/0", grant, busy);
    end
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 3'd4) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b idx=%0d want 1000/4", grant, grant_idx);
    end
    drain();
  endtask

  task automatic test_hold_limit();
    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (grant !== exp_grant() || grant_idx !== exp_idx() || busy !== m_busy) begin
        errors++;
        $display("FAIL hold_limit[%0d]: grant=%b idx=%0d busy=%b want %b/%0d/%b",
                 k, grant, grant_idx, busy, exp_grant(), exp_idx(), m_busy);
      end
      checks++;
      if (k < 4 && (grant !== 4'b1000 || grant_idx !== 3'd4 || busy !== 1'b1)) begin
        errors++;
        $display("FAIL hold_tenure[%0d]: grant=%b idx=%0d want 1000/4", k, grant, grant_idx);
      end else if (k == 4 && grant !== 4'b0000) begin
        errors++;
        $display("FAIL hold_release: grant=%b want 0000", grant);
      end
    end
    drain();
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      tick();
      want = ((k % 5) < 4) ? (4'b0001 << (3 - (k / 5) % 4)) : 4'b0000;
      checks++;
      if (grant !== want || busy !== (want != 4'b0000)) begin
        errors++;
        $display("FAIL rotation[%0d]: grant=%b busy=%b want %b", k, grant, busy, want);
      end
    end
    drain();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b1011;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_idx !== 3'd2 || grant !== exp_grant()) begin
      errors++;
      $display("FAIL drop_next: grant=%b idx=%0d want 0010/2", grant, grant_idx);
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (grant !== exp_grant() || grant_idx !== exp_idx()) begin
        errors++;
        $display("FAIL wrap[%0d]: grant=%b idx=%0d want %b/%0d", k, grant, grant_idx, exp_grant(), exp_idx());
      end
    end
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_winner: grant=%b want 1000", grant);
    end
    drain();
  endtask

  task automatic test_unlimited();
    int bad;
    do_reset();
    req2 = 4'b1000;
    tick();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (grant2 !== 4'b1000 || grant_idx2 !== 3'd4 || busy2 !== 1'b1) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL unlimited_hold[%0d]: grant=%b idx=%0d want 1000/4", k, grant2, grant_idx2);
      end
      tick();
    end
    req2 = 4'b0000;
    tick();
    checks++;
    if (grant2 !== 4'b0000) begin
      errors++;
      $display("FAIL unlimited_release: grant=%b want 0000", grant2);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: grant=%b idx=%0d busy=%b want 0000/0/0", grant, grant_idx, busy);
    end
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_idx !== 3'd3) begin
      errors++;
      $display("FAIL mid_reset_regrant: grant=%b idx=%0d want 0100/3", grant, grant_idx);
    end
    drain();
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (grant !== exp_grant() || grant_idx !== exp_idx() || busy !== m_busy) begin
        errors++;
        if (bad++ < 8)
          $display("FAIL random[%0d]: grant=%b idx=%0d busy=%b want %b/%0d/%b",
                   k, grant, grant_idx, busy, exp_grant(), exp_idx(), m_busy);
      end
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    req2  = 4'b0000;
    model_reset();
    #2 rst_n = 1'b0;
    test_reset();
    test_hold_limit();
    test_rotation();
    test_drop();
    test_wrap();
    test_unlimited();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
